ifetch_stage: RTL

//   Instruction-fetch stage: owns the PC and drives the instruction-memory/I-cache address.

---
 rtl/ifetch_stage.sv | 89 ++++++++
 1 files changed

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// captures returned words into an IF/ID register with a valid/ready handshake to decode.
module ifetch_stage #(
   parameter int unsigned     DATA     = 32,
   parameter int unsigned     ADDR     = 32,
   parameter logic [ADDR-1:0] RESET_PC = '0,
   parameter int unsigned     CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [ADDR-1:0]  pc_o,
   input  logic [DATA-1:0]  instr_i,
   input  logic             imem_ready_i,
   input  logic             redirect_i,
   input  logic [ADDR-1:0]  redirect_pc_i,
   input  logic             id_ready_i,
   output logic             if_valid_o,
   output logic [DATA-1:0]  if_instr_o,
   output logic [ADDR-1:0]  if_pc_o,
   output logic [ADDR-1:0]  if_pc4_o,
   output logic             misalign_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam logic [1:0] BOOT = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [ADDR-1:0] pc;
   logic [ADDR-1:0] pc_plus4;
   logic            slot_free;
   logic            capture;

   assign pc_o      = pc;
   assign pc_plus4  = pc + ADDR'(4);
   assign slot_free = !if_valid_o || id_ready_i;
   // Redirect discards the word on instr_i, so it also suppresses capture.
   assign capture   = (state != BOOT) && imem_ready_i && slot_free && !redirect_i;

   always_comb begin
      state_nxt = state;
      if (redirect_i) begin
         state_nxt = RUN;
      end else begin
         case (state)
            BOOT:    state_nxt = RUN;
            RUN:     state_nxt = imem_ready_i ? RUN : WAIT;
            WAIT:    state_nxt = imem_ready_i ? RUN : WAIT;
            default: state_nxt = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         if_valid_o  <= 1'b0;
         if_instr_o  <= '0;
         if_pc_o     <= '0;
         if_pc4_o    <= '0;
         misalign_o  <= 1'b0;
         stall_cnt_o <= '0;
      end else begin
         state <= state_nxt;
         if (state == WAIT && stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
         end
         if (redirect_i) begin
            pc         <= redirect_pc_i & ~ADDR'(3);
            if_valid_o <= 1'b0;
            if (redirect_pc_i[1:0] != 2'b00) begin
               misalign_o <= 1'b1;
            end
         end else if (capture) begin
            if_instr_o <= instr_i;
            if_pc_o    <= pc;
            if_pc4_o   <= pc_plus4;
            if_valid_o <= 1'b1;
            pc         <= pc_plus4;
         end else if (id_ready_i) begin
            if_valid_o <= 1'b0;
         end
      end
   end

endmodule
